// File: rtl/aes_pkg.sv
// Shared definitions for the AES session controllers: frame layout, header
// codes, key-size configuration, FSM states and error codes.
package aes_pkg;

  localparam int FRAME_W = 258;
  localparam int HDR_LO  = 0;
  localparam int HDR_W   = 2;
  localparam int KEY_LO  = 2;
  localparam int KEY_W   = 256;
  localparam int MSG_LO  = 130;
  localparam int MSG_W   = 128;

  typedef enum logic [1:0] {
    HDR_128 = 2'b00,
    HDR_192 = 2'b01,
    HDR_256 = 2'b10,
    HDR_MSG = 2'b11
  } hdr_e;

  typedef enum logic [2:0] {
    S_KEY    = 3'd0,
    S_EXPAND = 3'd1,
    S_MSG    = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_SIZE = 2'b01,
    ERR_TMO  = 2'b10,
    ERR_OVR  = 2'b11
  } err_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } cfg_t;

  localparam cfg_t CFG_128 = '{nk: 4'd4, nr: 4'd10};
  localparam cfg_t CFG_192 = '{nk: 4'd6, nr: 4'd12};
  localparam cfg_t CFG_256 = '{nk: 4'd8, nr: 4'd14};

  // Message-only headers fall back to the 128-bit pair; callers never load it.
  function automatic cfg_t hdr_cfg(input logic [1:0] hdr);
    case (hdr)
      HDR_192: return CFG_192;
      HDR_256: return CFG_256;
      default: return CFG_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_session_ctrl_if.sv
// Frame-side and cipher-side signals of the session controller.
interface aes_session_ctrl_if;
  import aes_pkg::*;

  logic               frame_done;
  logic [0:FRAME_W-1] frame;
  logic               err_clr;
  logic [3:0]         nk;
  logic [3:0]         nr;
  logic [255:0]       key;
  logic [127:0]       init;
  logic               cipher_cs;
  logic               cipher_flag;
  logic [127:0]       cipher_out;
  logic [127:0]       tx;
  logic               tx_valid;
  logic               busy;
  logic [1:0]         err_code;

  modport master (
    output frame_done, frame, err_clr, cipher_flag, cipher_out,
    input  nk, nr, key, init, cipher_cs, tx, tx_valid, busy, err_code
  );

  modport slave (
    input  frame_done, frame, err_clr, cipher_flag, cipher_out,
    output nk, nr, key, init, cipher_cs, tx, tx_valid, busy, err_code
  );
endinterface

// File: rtl/aes_session_ctrl.sv
// Sequences SPI key/message frames into KeyExpansion/Cipher runs, with
// expansion settle, cipher timeout, key reuse and sticky error reporting.
module aes_session_ctrl
  import aes_pkg::*;
#(
  parameter int EXP_WAIT = 4,
  parameter int TIMEOUT  = 64,
  parameter int CW       = 7
) (
  input  logic clk,
  input  logic rst,
  aes_session_ctrl_if.slave bus
);

  state_e        state, state_d;
  err_e          err_new;
  logic          fd_q, fe, pend, is_msg, exp_end, run_tmo, load_key, load_msg;
  logic [CW-1:0] cnt;
  logic [1:0]    hdr;
  cfg_t          cfg;

  assign fe      = bus.frame_done & ~fd_q;
  assign hdr     = bus.frame[HDR_LO +: HDR_W];
  assign is_msg  = (hdr == HDR_MSG);
  assign cfg     = hdr_cfg(hdr);
  assign exp_end = (cnt == CW'(EXP_WAIT - 1));
  assign run_tmo = (cnt == CW'(TIMEOUT - 1));

  assign load_key = fe & ~is_msg & ((state == S_KEY) | (state == S_DONE));
  assign load_msg = fe & ((state == S_EXPAND) | (state == S_MSG) |
                          ((state == S_DONE) & is_msg));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_KEY;
    else     state <= state_d;

  // A message arriving on the last settle cycle still counts as pending.
  always_comb begin
    state_d = state;
    err_new = ERR_NONE;
    unique case (state)
      S_KEY: begin
        if (fe && is_msg)  err_new = ERR_SIZE;
        if (fe && !is_msg) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        if (fe && pend) err_new = ERR_OVR;
        if (exp_end)    state_d = (pend || fe) ? S_RUN : S_MSG;
      end
      S_MSG:
        if (fe) state_d = S_RUN;
      S_RUN: begin
        if (fe) err_new = ERR_OVR;
        if (bus.cipher_flag) state_d = S_DONE;
        else if (run_tmo) begin
          state_d = S_KEY;
          err_new = ERR_TMO;
        end
      end
      S_DONE:
        if (fe) state_d = is_msg ? S_RUN : S_EXPAND;
      default: state_d = S_KEY;
    endcase
  end

  always_comb begin
    bus.cipher_cs = (state == S_RUN);
    bus.busy      = (state == S_EXPAND) || (state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fd_q         <= 1'b0;
      pend         <= 1'b0;
      cnt          <= '0;
      bus.nk       <= CFG_128.nk;
      bus.nr       <= CFG_128.nr;
      bus.key      <= '0;
      bus.init     <= '0;
      bus.tx       <= '0;
      bus.tx_valid <= 1'b0;
      bus.err_code <= ERR_NONE;
    end else begin
      fd_q <= bus.frame_done;

      // Counter restarts on every state change, so entry to EXPAND/RUN sees 0.
      if (state_d != state)                        cnt <= '0;
      else if (state == S_EXPAND || state == S_RUN) cnt <= cnt + 1'b1;

      if (state == S_RUN)              pend <= 1'b0;
      else if (state == S_EXPAND && fe) pend <= 1'b1;

      if (load_key) begin
        bus.nk  <= cfg.nk;
        bus.nr  <= cfg.nr;
        bus.key <= bus.frame[KEY_LO +: KEY_W];
      end
      if (load_msg) bus.init <= bus.frame[MSG_LO +: MSG_W];

      if (state == S_RUN && bus.cipher_flag) begin
        bus.tx       <= bus.cipher_out;
        bus.tx_valid <= 1'b1;
      end else if (state == S_DONE && fe) begin
        bus.tx_valid <= 1'b0;
      end

      if (err_new != ERR_NONE) bus.err_code <= err_new;
      else if (bus.err_clr)    bus.err_code <= ERR_NONE;
    end

endmodule

// File: doc/aes_session_ctrl.md
Name: aes_session_ctrl

Overview:
- Clocked sequencer between the SPI subordinate frame interface and the KeyExpansion/Cipher datapath.
- Decodes key and message frames and drives the Nk/Nr/key configuration, then waits a fixed key-expansion settle time.
- Starts the cipher, bounds it with a timeout, and loads the 128-bit result into the SPI transmit register.
- Supports key reuse: after a result, message-only frames encrypt under the retained key. Replaces ad-hoc frame-edge sequencing with a single-clock FSM.

Parameters:
- EXP_WAIT, 4, cycles between key update and earliest cipher start (KeyExpansion settle); must be >=1.
- TIMEOUT, 64, max cycles cipher_cs may stay high without cipher_flag before error.
- CW, 7, counter width; must satisfy 2^CW > max(EXP_WAIT, TIMEOUT).

Ports:
- clk, in, 1, single system clock; all logic on posedge.
- rst, in, 1, asynchronous active-high reset.
- frame_done, in, 1, SPI frame complete level, already in clk domain; the controller edge-detects it internally.
- frame, in, 258, received frame; bit 0 = MSB. Bits 0:1 are the header; bits 2:257 carry the key; bits 130:257 carry the message.
- err_clr, in, 1, clears err_code.
- nk, out, 4, key words to KeyExpansion.
- nr, out, 4, rounds to KeyExpansion/Cipher.
- key, out, 256, key to KeyExpansion.
- init, out, 128, plaintext to Cipher.
- cipher_cs, out, 1, Cipher start/enable level.
- cipher_flag, in, 1, Cipher result valid.
- cipher_out, in, 128, Cipher result.
- tx, out, 128, SPI transmit data.
- tx_valid, out, 1, tx holds a fresh result.
- busy, out, 1, high in S_EXPAND and S_RUN.
- err_code, out, 2, sticky error: 00 none, 01 bad size, 10 timeout, 11 overrun.

Behaviour:
- Reset values:
  - nk=4, nr=10; key, init and tx all zero.
  - cipher_cs=0, tx_valid=0, busy=0, err_code=00, pend=0, counter=0.
  - State = S_KEY.
  - Reset mid-operation aborts immediately, with no partial result.
- Frame event (fe) = frame_done high and frame_done_q low (registered previous value). The fe action takes effect at the next posedge.
- Header decode: 00 gives nk=4/nr=10; 01 gives nk=6/nr=12; 10 gives nk=8/nr=14. Header 11 is "message-only".
- S_KEY:
  - fe with header 00/01/10: latch nk, nr and key = frame[2:257]; clear counter; go to S_EXPAND.
  - fe with header 11: err_code=01; stay in S_KEY.
- S_EXPAND:
  - Counter increments each cycle.
  - fe here: latch init = frame[130:257] and set pend=1. A second fe while pend=1 overwrites init and sets err_code=11.
  - When counter == EXP_WAIT-1: go to S_RUN if pend=1, else to S_MSG.
- S_MSG: fe with any header latches init = frame[130:257] and goes to S_RUN.
- S_RUN:
  - cipher_cs=1; counter cleared on entry and increments each cycle; pend cleared.
  - cipher_flag=1: tx <= cipher_out, tx_valid=1, cipher_cs=0, go to S_DONE.
  - No flag within TIMEOUT cycles: err_code=10, cipher_cs=0, tx_valid=0, go to S_KEY (key retained but considered stale).
  - fe in S_RUN is dropped and sets err_code=11.
- S_DONE:
  - cipher_cs=0 (guaranteed >=1 low cycle before any restart).
  - fe with header 11: init = frame[130:257], tx_valid=0, go to S_RUN (key reused).
  - fe with header 00/01/10: new key as in S_KEY, tx_valid=0, go to S_EXPAND.
- Latency: from message fe to cipher_cs high is 1 cycle (from S_MSG or S_DONE). From cipher_flag to tx_valid is 1 cycle.
- Simultaneous events:
  - cipher_flag and timeout expiry in the same cycle: flag wins.
  - err_clr and a new error in the same cycle: the new error wins.
  - err_code holds its last error (latest overwrites) until err_clr or rst.

Decomposition:
- Shared package aes_pkg: header codes (HDR_128=00, HDR_192=01, HDR_256=10, HDR_MSG=11), Nk/Nr constant pairs, state encoding, err_code values, frame bit-field offsets.
- No sub-module required. The header-to-Nk/Nr decode is a function in aes_pkg, shared with any future decrypt controller.

Test Plan:
- Reset -> key frame hdr 00 with key 2b7e1516...09cf4f3c -> EXP_WAIT cycles -> message frame 3243f6a8...0734 -> nk=4, nr=10, cipher_cs high 1 cycle after fe; model flag returns 3925841d...0b32 -> tx equals it, tx_valid=1, cipher_cs=0.
- Message frame sent 1 cycle after key frame (during S_EXPAND) -> pend=1, cipher_cs rises exactly at EXP_WAIT boundary, err_code=00.
- After a result, frame hdr 11 with a new plaintext -> no S_EXPAND, cipher_cs high 1 cycle after fe, key and nk unchanged, tx_valid drops then reasserts.
- Key frame hdr 10 -> nk=8, nr=14; first frame hdr 11 from S_KEY -> err_code=01, state stays S_KEY; err_clr -> 00.
- Hold cipher_flag low for TIMEOUT cycles -> err_code=10, cipher_cs=0, state S_KEY; a frame during S_RUN -> err_code=11.
- Assert rst in S_RUN -> all outputs return to reset values asynchronously; next key frame proceeds normally.
